// File: rtl/alarm_beeper.sv
// alarm_beeper: turns the level alarm request into a gated piezo beep pattern,
// with stop/snooze handling, a per-event snooze limit and a ring timeout.
//
// state  | meaning
// IDLE   | no alarm pending, waiting for alarm_in
// RING   | beeping, ring timeout running
// SNOOZE | silent, snooze timer running
// DONE   | stopped or timed out, silent until alarm_in drops
module alarm_beeper #(
    parameter int unsigned TONE_HALF   = 25000,
    parameter int unsigned BEEP_ON     = 12500000,
    parameter int unsigned BEEP_OFF    = 12500000,
    parameter int unsigned SNOOZE_CYC  = 250000000,
    parameter int unsigned TIMEOUT_CYC = 32'd3000000000,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alarm_in,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       buzzer,
    output logic       ring_led,
    output logic       snooze_led,
    output logic [1:0] snooze_cnt
);

    localparam int unsigned TONE_W = (TONE_HALF   > 1) ? $clog2(TONE_HALF)   : 1;
    localparam int unsigned ON_W   = (BEEP_ON     > 1) ? $clog2(BEEP_ON)     : 1;
    localparam int unsigned OFF_W  = (BEEP_OFF    > 1) ? $clog2(BEEP_OFF)    : 1;
    localparam int unsigned GATE_W = (ON_W > OFF_W) ? ON_W : OFF_W;
    localparam int unsigned SNZ_W  = (SNOOZE_CYC  > 1) ? $clog2(SNOOZE_CYC)  : 1;
    localparam int unsigned TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
    localparam logic [GATE_W-1:0] ON_LAST   = GATE_W'(BEEP_ON - 1);
    localparam logic [GATE_W-1:0] OFF_LAST  = GATE_W'(BEEP_OFF - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]        SNZ_MAX   = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE, DONE} state_t;

    state_t            state_q, state_d;
    logic              stop_q, snooze_q;
    logic              stop_rise, snooze_rise;
    logic [1:0]        snz_used_q, snz_used_d;
    logic [TONE_W-1:0] tone_cnt;
    logic              tone_q;
    logic [GATE_W-1:0] gate_cnt;
    logic              gate_q;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [SNZ_W-1:0]  snz_tmr;

    assign stop_rise   = stop_btn & ~stop_q;
    assign snooze_rise = snooze_btn & ~snooze_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            stop_q     <= 1'b0;
            snooze_q   <= 1'b0;
            snz_used_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            stop_q     <= stop_btn;
            snooze_q   <= snooze_btn;
            snz_used_q <= snz_used_d;
        end
    end

    // Branch order encodes priority: alarm drop, stop, snooze, timers.
    always_comb begin
        state_d    = state_q;
        snz_used_d = snz_used_q;
        case (state_q)
            IDLE: begin
                if (alarm_in) state_d = RING;
            end
            RING: begin
                if (!alarm_in) begin
                    state_d    = IDLE;
                    snz_used_d = 2'd0;
                end else if (stop_rise) begin
                    state_d = DONE;
                end else if (snooze_rise && (snz_used_q < SNZ_MAX)) begin
                    state_d    = SNOOZE;
                    snz_used_d = snz_used_q + 2'd1;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d = DONE;
                end
            end
            SNOOZE: begin
                if (!alarm_in) begin
                    state_d    = IDLE;
                    snz_used_d = 2'd0;
                end else if (stop_rise) begin
                    state_d = DONE;
                end else if (snz_tmr == SNZ_LAST) begin
                    state_d = RING;
                end
            end
            DONE: begin
                if (!alarm_in) begin
                    state_d    = IDLE;
                    snz_used_d = 2'd0;
                end
            end
            default: begin
                state_d    = IDLE;
                snz_used_d = 2'd0;
            end
        endcase
    end

    // Tone, gate and timeout restart on every RING entry and rest at zero outside RING.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tone_cnt <= '0;
            tone_q   <= 1'b0;
            gate_cnt <= '0;
            gate_q   <= 1'b0;
            tmo_cnt  <= '0;
        end else if (state_d != RING) begin
            tone_cnt <= '0;
            tone_q   <= 1'b0;
            gate_cnt <= '0;
            gate_q   <= 1'b0;
            tmo_cnt  <= '0;
        end else if (state_q != RING) begin
            tone_cnt <= '0;
            tone_q   <= 1'b1;
            gate_cnt <= '0;
            gate_q   <= 1'b1;
            tmo_cnt  <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tone_cnt == TONE_LAST) begin
                tone_cnt <= '0;
                tone_q   <= ~tone_q;
            end else begin
                tone_cnt <= tone_cnt + TONE_W'(1);
            end
            if (gate_q ? (gate_cnt == ON_LAST) : (gate_cnt == OFF_LAST)) begin
                gate_cnt <= '0;
                gate_q   <= ~gate_q;
            end else begin
                gate_cnt <= gate_cnt + GATE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snz_tmr <= '0;
        end else if ((state_q == SNOOZE) && (state_d == SNOOZE)) begin
            snz_tmr <= snz_tmr + SNZ_W'(1);
        end else begin
            snz_tmr <= '0;
        end
    end

    assign buzzer     = (state_q == RING) & tone_q & gate_q;
    assign ring_led   = (state_q == RING);
    assign snooze_led = (state_q == SNOOZE);
    assign snooze_cnt = snz_used_q;

endmodule

// File: tb/tb_alarm_beeper.sv
// Directed bench for alarm_beeper with small timing parameters: a vector table
// for the short sequences plus hand-written multi-cycle scenarios.
module tb_alarm_beeper;

    localparam int TONE_HALF   = 2;
    localparam int BEEP_ON     = 8;
    localparam int BEEP_OFF    = 4;
    localparam int SNOOZE_CYC  = 20;
    localparam int TIMEOUT_CYC = 40;
    localparam int MAX_SNOOZE  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       alarm_in;
    logic       stop_btn;
    logic       snooze_btn;
    logic       buzzer;
    logic       ring_led;
    logic       snooze_led;
    logic [1:0] snooze_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       alarm;
        logic       stop;
        logic       snooze;
        logic       buzz;
        logic       ring;
        logic       snz;
        logic [1:0] cnt;
    } vec_t;

    vec_t vecs[25];

    alarm_beeper #(
        .TONE_HALF  (TONE_HALF),
        .BEEP_ON    (BEEP_ON),
        .BEEP_OFF   (BEEP_OFF),
        .SNOOZE_CYC (SNOOZE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .alarm_in  (alarm_in),
        .stop_btn  (stop_btn),
        .snooze_btn(snooze_btn),
        .buzzer    (buzzer),
        .ring_led  (ring_led),
        .snooze_led(snooze_led),
        .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected buzzer k cycles after RING entry: 12-cycle beep period, 1 kHz-style 1,1,0,0 tone.
    function automatic logic exp_buzz(input int k);
        int p;
        p = k % (BEEP_ON + BEEP_OFF);
        return (p < BEEP_ON) && ((p % (2 * TONE_HALF)) < TONE_HALF);
    endfunction

    initial begin
        int rl;
        int pat_err;
        int n;
        int snz_cyc;

        // alarm stop snz | buzz ring sled cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[22] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

        reset      = 1'b0;
        alarm_in   = 1'b0;
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        repeat (3) tick();
        check("reset_buzzer", buzzer, 0);
        check("reset_ring_led", ring_led, 0);
        check("reset_snooze_led", snooze_led, 0);
        check("reset_snooze_cnt", snooze_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 25; i++) begin
            alarm_in   = vecs[i].alarm;
            stop_btn   = vecs[i].stop;
            snooze_btn = vecs[i].snooze;
            tick();
            check($sformatf("vec%0d_buzzer", i), buzzer, vecs[i].buzz);
            check($sformatf("vec%0d_ring_led", i), ring_led, vecs[i].ring);
            check($sformatf("vec%0d_snooze_led", i), snooze_led, vecs[i].snz);
            check($sformatf("vec%0d_snooze_cnt", i), snooze_cnt, vecs[i].cnt);
        end
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        tick();

        // Ring timeout, DONE hold, then re-arm only after alarm_in drops.
        alarm_in = 1'b1;
        tick();
        rl      = 0;
        pat_err = 0;
        while (ring_led === 1'b1 && rl < 100) begin
            if (buzzer !== exp_buzz(rl)) pat_err++;
            rl++;
            tick();
        end
        check("timeout_ring_len", rl, TIMEOUT_CYC);
        check("ring_pattern_errs", pat_err, 0);
        check("done_buzzer", buzzer, 0);
        check("done_snooze_led", snooze_led, 0);
        repeat (3) tick();
        check("done_holds", ring_led, 0);
        alarm_in = 1'b0;
        tick();
        alarm_in = 1'b1;
        tick();
        check("rearm_after_done", ring_led, 1);
        alarm_in = 1'b0;
        tick();

        // Held snooze acts once; snooze limit; fresh timeout after snooze.
        alarm_in   = 1'b1;
        tick();
        snooze_btn = 1'b1;
        snz_cyc    = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (snooze_led === 1'b1) snz_cyc++;
            if (i == 1) check("snooze1_cnt", snooze_cnt, 1);
            if (i == 21) begin
                check("snooze1_end_ring", ring_led, 1);
                check("snooze1_end_buzzer", buzzer, 1);
            end
        end
        check("held_snooze_len", snz_cyc, SNOOZE_CYC);
        check("held_snooze_ring", ring_led, 1);
        check("held_snooze_cnt", snooze_cnt, 1);
        snooze_btn = 1'b0;
        tick();
        snooze_btn = 1'b1;
        tick();
        check("snooze2_led", snooze_led, 1);
        check("snooze2_cnt", snooze_cnt, 2);
        snooze_btn = 1'b0;
        n = 0;
        while (snooze_led === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("snooze2_len", n, SNOOZE_CYC);
        check("snooze2_end_buzzer", buzzer, 1);
        snooze_btn = 1'b1;
        tick();
        check("snooze3_ring", ring_led, 1);
        check("snooze3_led", snooze_led, 0);
        check("snooze3_cnt", snooze_cnt, 2);
        snooze_btn = 1'b0;
        rl = 1;
        while (ring_led === 1'b1 && rl < 100) begin
            rl++;
            tick();
        end
        check("fresh_timeout_len", rl, TIMEOUT_CYC);
        check("done_cnt_hold", snooze_cnt, 2);
        alarm_in = 1'b0;
        tick();
        check("idle_cnt_clear", snooze_cnt, 0);

        // Stop and snooze rising together: stop wins, count unchanged.
        alarm_in   = 1'b1;
        tick();
        snooze_btn = 1'b1;
        tick();
        snooze_btn = 1'b0;
        n = 0;
        while (snooze_led === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("pre_both_ring", ring_led, 1);
        stop_btn   = 1'b1;
        snooze_btn = 1'b1;
        tick();
        check("both_ring_led", ring_led, 0);
        check("both_snooze_led", snooze_led, 0);
        check("both_cnt", snooze_cnt, 1);
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        alarm_in   = 1'b0;
        tick();
        check("both_idle_cnt", snooze_cnt, 0);

        // Stop during SNOOZE goes to DONE and stays silent.
        alarm_in   = 1'b1;
        tick();
        snooze_btn = 1'b1;
        tick();
        snooze_btn = 1'b0;
        stop_btn   = 1'b1;
        tick();
        check("stop_in_snooze_led", snooze_led, 0);
        repeat (25) tick();
        check("stop_in_snooze_done", ring_led, 0);
        stop_btn = 1'b0;
        alarm_in = 1'b0;
        tick();

        // Alarm drop beats a stop press in the same cycle.
        alarm_in = 1'b1;
        tick();
        alarm_in = 1'b0;
        stop_btn = 1'b1;
        tick();
        stop_btn = 1'b0;
        alarm_in = 1'b1;
        tick();
        check("drop_beats_stop", ring_led, 1);

        // Async reset mid-RING silences immediately; release re-enters RING one edge later.
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_buzzer", buzzer, 0);
        check("async_rst_ring_led", ring_led, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_idle", ring_led, 0);
        tick();
        check("post_rst_ring", ring_led, 1);
        check("post_rst_buzzer", buzzer, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
